// File: rtl/ad7822_reader_if.sv
// Signal bundle between one AD7822 reader and its ADC pins / downstream sample consumer.
// The master modport is the reader; the slave modport is the ADC plus the sample sink.
interface ad7822_reader_if;
  logic       enable;
  logic [7:0] adc_data;
  logic       eoc_n;
  logic       convst_n;
  logic       cs_n;
  logic       rd_n;
  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       timeout;

  modport master (
    input  enable, adc_data, eoc_n,
    output convst_n, cs_n, rd_n, data, valid, busy, timeout
  );

  modport slave (
    output enable, adc_data, eoc_n,
    input  convst_n, cs_n, rd_n, data, valid, busy, timeout
  );
endinterface

// File: rtl/ad7822_reader.sv
// AD7822 acquisition front end: paced CONVST, EOC wait with timeout, CS/RD read,
// and a one-cycle valid strobe per published sample.
module ad7822_reader #(
  parameter int unsigned SAMPLE_DIV = 500,
  parameter int unsigned T_CONVST   = 2,
  parameter int unsigned T_RD       = 3,
  parameter int unsigned T_TIMEOUT  = 100
) (
  input logic             i_clock,
  input logic             i_reset_n,
  ad7822_reader_if.master bus
);

  localparam int unsigned CntMaxA = (T_CONVST > T_RD) ? T_CONVST : T_RD;
  localparam int unsigned CntMax  = (CntMaxA > T_TIMEOUT) ? CntMaxA : T_TIMEOUT;
  localparam int unsigned CntW    = $clog2(CntMax + 1);
  localparam int unsigned TmrW    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  typedef enum logic [2:0] {StIdle, StConv, StWait, StRead, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic              eoc_meta_q, eoc_s_q;
  logic              tick;
  logic              convst_n_q, convst_n_d;
  logic              rd_n_q, rd_n_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        data_q, data_d;

  // EOC_n is asynchronous to i_clock; only the second stage is used.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      eoc_meta_q <= 1'b1;
      eoc_s_q    <= 1'b1;
    end else begin
      eoc_meta_q <= bus.eoc_n;
      eoc_s_q    <= eoc_meta_q;
    end
  end

  assign tick = bus.enable && (tmr_q == TmrW'(SAMPLE_DIV - 1));

  always_comb begin
    tmr_d = '0;
    if (bus.enable && !tick) begin
      tmr_d = tmr_q + 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    data_d    = data_q;
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          state_d = StConv;
          cnt_d   = '0;
        end
      end
      StConv: begin
        if (cnt_q == CntW'(T_CONVST - 1)) begin
          state_d = StWait;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWait: begin
        // EOC takes priority over a timeout landing on the same cycle.
        if (!eoc_s_q) begin
          state_d = StRead;
          cnt_d   = '0;
        end else if (cnt_q == CntW'(T_TIMEOUT - 1)) begin
          state_d   = StIdle;
          cnt_d     = '0;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRead: begin
        if (cnt_q == CntW'(T_RD - 1)) begin
          state_d = StDone;
          cnt_d   = '0;
          data_d  = bus.adc_data;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with the state register.
    convst_n_d = (state_d != StConv);
    rd_n_d     = (state_d != StRead);
    valid_d    = (state_d == StDone);
    busy_d     = (state_d != StIdle);
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      tmr_q      <= '0;
      convst_n_q <= 1'b1;
      rd_n_q     <= 1'b1;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      convst_n_q <= convst_n_d;
      rd_n_q     <= rd_n_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      data_q     <= data_d;
    end
  end

  assign bus.convst_n = convst_n_q;
  assign bus.cs_n     = rd_n_q;
  assign bus.rd_n     = rd_n_q;
  assign bus.data     = data_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = timeout_q;

endmodule
